// File: rtl/limb_pkg.sv
// Shared types and constants for the memory arbiter: FSM encoding, port ids, word width,
// and the address range check used by the arbiter.
package limb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                           input int unsigned words);
        return addr < words;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection for the memory arbiter. Define ARB_ROUND_ROBIN_EN to
// alternate ties using the last grant; otherwise load/store always wins a tie.
module mem_arb_select
    import limb_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last_grant,
    output logic winner
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        winner = PORT_IF;
        if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = (last_grant == PORT_IF) ? PORT_LS : PORT_IF;
`else
            winner = PORT_LS;
`endif
        end else if (ls_req) begin
            winner = PORT_LS;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch, load/store) arbiter in front of a single registered-read RAM.
// One transaction per IDLE->ISSUE->WAIT pass; ARB_ROUND_ROBIN_EN selects round-robin ties.
module memory_arbiter
    import limb_pkg::*;
#(
    parameter int MEM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_a,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_err,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [WORD_W-1:0] ls_a,
    input  logic [WORD_W-1:0] ls_din,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic              ls_err,
    output logic [WORD_W-1:0] ls_rdata,
    output logic [WORD_W-1:0] ram_a,
    output logic [WORD_W-1:0] ram_din,
    output logic              ram_rw,
    input  logic [WORD_W-1:0] ram_dout,
    output arb_state_t        dbg_state
);

    // Handshake: a request is taken at an IDLE edge; gnt pulses in ISSUE, and rvalid
    // (with rdata/err) pulses in the following IDLE cycle. Writes are acked by rvalid.
    arb_state_t        state, state_next;
    logic              winner;
    logic              sel;
    logic              sel_last;
    logic              oor;
    logic [WORD_W-1:0] sel_addr;
    logic              sel_in_range;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign sel_last = last_grant;
`else
    assign sel_last = PORT_IF;
`endif

    mem_arb_select u_select (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_grant (sel_last),
        .winner     (sel)
    );

    assign sel_addr     = (sel == PORT_LS) ? ls_a : if_a;
    assign sel_in_range = addr_in_range(sel_addr, MEM_WORDS);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (if_req || ls_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= PORT_IF;
            oor       <= 1'b0;
            ram_a     <= '0;
            ram_din   <= '0;
            ram_rw    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= PORT_IF;
`endif
        end else begin
            state     <= state_next;
            ram_rw    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        winner  <= sel;
                        oor     <= !sel_in_range;
                        ram_a   <= sel_addr;
                        ram_din <= (sel == PORT_LS) ? ls_din : '0;
                        ram_rw  <= (sel == PORT_LS) && ls_rw && sel_in_range;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= sel;
`endif
                    end
                end
                WAIT: begin
                    // Out-of-range accesses never touched the RAM, so return zero data.
                    if (winner == PORT_LS) begin
                        ls_rvalid <= 1'b1;
                        ls_err    <= oor;
                        ls_rdata  <= oor ? '0 : ram_dout;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_err    <= oor;
                        if_rdata  <= oor ? '0 : ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_gnt    = (state == ISSUE) && (winner == PORT_IF);
    assign ls_gnt    = (state == ISSUE) && (winner == PORT_LS);
    assign dbg_state = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a registered-read RAM model.
// Honors ARB_ROUND_ROBIN_EN for the expected tie order.
module tb_memory_arbiter;
    import limb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_rw;
    logic [31:0] if_a, ls_a, ls_din;
    logic        if_gnt, if_rvalid, if_err;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] if_rdata, ls_rdata;
    logic [31:0] ram_a, ram_din, ram_dout;
    logic        ram_rw;
    arb_state_t  dbg_state;

    logic [31:0] mem [0:8191];
    int checks = 0;
    int failures = 0;

    memory_arbiter #(.MEM_WORDS(8192)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_a(if_a), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_err(if_err), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_a(ls_a), .ls_din(ls_din),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .ram_a(ram_a), .ram_din(ram_din), .ram_rw(ram_rw), .ram_dout(ram_dout),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // RAM model: write on strobe, registered read of the sampled address
    always @(posedge clk) begin
        if (ram_rw) mem[ram_a[12:0]] <= ram_din;
        ram_dout <= mem[ram_a[12:0]];
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic exp_ls;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[0] = 32'h0BAD_0BAD;
        mem[5] = 32'hDEAD_BEEF;
        ram_dout = '0;
        if_req = 0; ls_req = 0; ls_rw = 0;
        if_a = '0; ls_a = '0; ls_din = '0;
        @(negedge clk);
        do_reset();

        // reset state
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
        chk("rst_rvalid_err", {28'd0, if_rvalid, ls_rvalid, if_err, ls_err}, 32'd0);
        chk("rst_ram_rw", 32'(ram_rw), 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);

        // fetch read of word 5
        if_req = 1; if_a = 32'd5;
        step();
        chk("fetch_gnt", 32'(if_gnt), 32'd1);
        chk("fetch_ls_gnt", 32'(ls_gnt), 32'd0);
        chk("fetch_state_issue", 32'(dbg_state), 32'(ISSUE));
        chk("fetch_ram_a", ram_a, 32'd5);
        chk("fetch_ram_rw", 32'(ram_rw), 32'd0);
        if_req = 0;
        step();
        chk("fetch_gnt_one_cycle", 32'(if_gnt), 32'd0);
        chk("fetch_state_wait", 32'(dbg_state), 32'(WAIT));
        chk("fetch_rvalid_early", 32'(if_rvalid), 32'd0);
        step();
        chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("fetch_err", 32'(if_err), 32'd0);
        chk("fetch_state_idle", 32'(dbg_state), 32'(IDLE));
        step();
        chk("fetch_rvalid_pulse", 32'(if_rvalid), 32'd0);

        // store 0x12345678 to word 10
        ls_req = 1; ls_rw = 1; ls_a = 32'd10; ls_din = 32'h1234_5678;
        step();
        chk("store_gnt", 32'(ls_gnt), 32'd1);
        chk("store_ram_rw", 32'(ram_rw), 32'd1);
        chk("store_ram_din", ram_din, 32'h1234_5678);
        chk("store_ram_a", ram_a, 32'd10);
        ls_req = 0; ls_rw = 0; ls_din = '0;
        step();
        chk("store_ram_rw_drop", 32'(ram_rw), 32'd0);
        step();
        chk("store_ack", 32'(ls_rvalid), 32'd1);
        chk("store_err", 32'(ls_err), 32'd0);
        chk("store_ram_rw_idle", 32'(ram_rw), 32'd0);
        chk("store_mem", mem[10], 32'h1234_5678);

        // load back word 10
        ls_req = 1; ls_rw = 0; ls_a = 32'd10;
        step();
        chk("load_gnt", 32'(ls_gnt), 32'd1);
        chk("load_ram_rw", 32'(ram_rw), 32'd0);
        ls_req = 0;
        step();
        step();
        chk("load_rvalid", 32'(ls_rvalid), 32'd1);
        chk("load_rdata", ls_rdata, 32'h1234_5678);
        chk("load_if_rdata_hold", if_rdata, 32'hDEAD_BEEF);
        chk("load_if_rvalid", 32'(if_rvalid), 32'd0);

        // out-of-range write
        ls_req = 1; ls_rw = 1; ls_a = 32'd8192; ls_din = 32'hAAAA_5555;
        step();
        chk("oor_gnt", 32'(ls_gnt), 32'd1);
        chk("oor_ram_rw_issue", 32'(ram_rw), 32'd0);
        ls_req = 0; ls_rw = 0;
        step();
        chk("oor_ram_rw_wait", 32'(ram_rw), 32'd0);
        chk("oor_err_early", 32'(ls_err), 32'd0);
        step();
        chk("oor_rvalid", 32'(ls_rvalid), 32'd1);
        chk("oor_err", 32'(ls_err), 32'd1);
        chk("oor_rdata", ls_rdata, 32'd0);
        chk("oor_mem0", mem[0], 32'h0BAD_0BAD);
        step();
        chk("oor_err_pulse", 32'(ls_err), 32'd0);

        // reset during WAIT of a fetch
        if_req = 1; if_a = 32'd5;
        step();
        chk("rw_gnt", 32'(if_gnt), 32'd1);
        if_req = 0;
        step();
        chk("rw_state_wait", 32'(dbg_state), 32'(WAIT));
        rst = 1;
        step();
        rst = 0;
        chk("rw_no_rvalid", 32'(if_rvalid), 32'd0);
        chk("rw_state", 32'(dbg_state), 32'(IDLE));
        chk("rw_if_rdata", if_rdata, 32'd0);
        chk("rw_ls_rdata", ls_rdata, 32'd0);
        chk("rw_ram_a", ram_a, 32'd0);
        chk("rw_gnt_off", {30'd0, if_gnt, ls_gnt}, 32'd0);
        if_req = 1; if_a = 32'd5;
        step();
        chk("rw_new_gnt", 32'(if_gnt), 32'd1);
        if_req = 0;
        step();
        step();
        chk("rw_new_rvalid", 32'(if_rvalid), 32'd1);
        chk("rw_new_rdata", if_rdata, 32'hDEAD_BEEF);

        // reset overrides a request sampled on the same edge
        ls_req = 1; ls_a = 32'd10; ls_rw = 0;
        do_reset();
        chk("rst_override_state", 32'(dbg_state), 32'(IDLE));

        // tie, both held: fresh reset so the round-robin tracker starts at fetch
        if_req = 1; if_a = 32'd5;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            step();
            chk($sformatf("tie%0d_ls_gnt", k), 32'(ls_gnt), 32'(exp_ls));
            chk($sformatf("tie%0d_if_gnt", k), 32'(if_gnt), 32'(!exp_ls));
            step();
            step();
            chk($sformatf("tie%0d_ls_rvalid", k), 32'(ls_rvalid), 32'(exp_ls));
            chk($sformatf("tie%0d_if_rvalid", k), 32'(if_rvalid), 32'(!exp_ls));
            if (exp_ls) chk($sformatf("tie%0d_ls_rdata", k), ls_rdata, 32'h1234_5678);
            else        chk($sformatf("tie%0d_if_rdata", k), if_rdata, 32'hDEAD_BEEF);
        end

        // the held fetch wins once load/store drops
        ls_req = 0;
        step();
        chk("loser_gnt", 32'(if_gnt), 32'd1);
        if_req = 0;
        step();
        step();
        chk("loser_rvalid", 32'(if_rvalid), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
